// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_pkg
// Description : Shared constants and state encodings for the AXI4-Lite
//               address-window bridge.
//               Optional macro ADDR_WINDOW_CHECK_EN adds the DECERR states.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    R_IDLE = 3'd0,
    R_AR   = 3'd1,
    R_WAIT = 3'd2,
    R_RESP = 3'd3
`ifdef ADDR_WINDOW_CHECK_EN
    , R_ERR = 3'd4
`endif
  } rd_state_t;

  typedef enum logic [2:0] {
    W_IDLE = 3'd0,
    W_FWD  = 3'd1,
    W_WAIT = 3'd2,
    W_RESP = 3'd3
`ifdef ADDR_WINDOW_CHECK_EN
    , W_ERR = 3'd4
`endif
  } wr_state_t;

endpackage : axil_pkg
`default_nettype wire

// File: rtl/axil_addr_xlate.sv
`default_nettype none
// ============================================================================
// Module      : axil_addr_xlate
// Description : Combinational address translation for one AXI address
//               channel: off = addr - OFFSET, out = off << LEFT_SHIFT, plus
//               an unsigned window test on the pre-shift offset.
// Ports       : i_addr     - incoming byte address
//               o_addr     - translated address (32-bit truncated)
//               o_in_range - 1 when WINDOW_SIZE==0 or off < WINDOW_SIZE
// Revision    : 1.0 - initial release
// ============================================================================
module axil_addr_xlate #(
  parameter logic [31:0] OFFSET      = 32'h0,
  parameter int unsigned LEFT_SHIFT  = 0,
  parameter logic [31:0] WINDOW_SIZE = 32'h0
) (
  input  logic [31:0] i_addr,
  output logic [31:0] o_addr,
  output logic        o_in_range
);

  logic [31:0] w_off;

  // Subtraction wraps modulo 2^32, so addresses below OFFSET land high and
  // fail the window test rather than aliasing into the window.
  assign w_off      = i_addr - OFFSET;
  assign o_addr     = w_off << LEFT_SHIFT;
  assign o_in_range = (WINDOW_SIZE == 32'h0) || (w_off < WINDOW_SIZE);

endmodule : axil_addr_xlate
`default_nettype wire

// File: rtl/axil_window_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axil_window_bridge
// Description : Registered AXI4-Lite address-window bridge. Rebases slave-side
//               addresses (subtract OFFSET, shift left by LEFT_SHIFT) and
//               forwards them to the master port, one outstanding read and
//               one outstanding write. Every output is a register or a state
//               decode.
//               Macro ADDR_WINDOW_CHECK_EN: when defined, requests outside
//               WINDOW_SIZE are answered locally with DECERR; when undefined
//               every request is forwarded and WINDOW_SIZE is ignored.
// Ports       : clk, rstn           - clock, synchronous active-low reset
//               s_ar*/s_r*          - slave read address / data channels
//               s_aw*/s_w*/s_b*     - slave write address / data / response
//               m_*                 - mirror-image master port
// Revision    : 1.0 - initial release
// ============================================================================
module axil_window_bridge
  import axil_pkg::*;
#(
  parameter logic [31:0] OFFSET      = 32'h0,
  parameter int unsigned LEFT_SHIFT  = 0,
  parameter logic [31:0] WINDOW_SIZE = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  // slave read
  input  logic [31:0] s_araddr,
  input  logic [2:0]  s_arprot,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  // slave write
  input  logic [31:0] s_awaddr,
  input  logic [2:0]  s_awprot,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  // master read
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  // master write
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  // Holds the slave readies low during reset and lets them rise on the
  // first cycle after rstn is sampled high.
  logic r_live;

  always_ff @(posedge clk) begin
    if (!rstn) r_live <= 1'b0;
    else       r_live <= 1'b1;
  end

  // --------------------------------------------------------------------------
  // Address translation
  // --------------------------------------------------------------------------
  logic [31:0] w_ar_xaddr;
  logic        w_ar_in_range;
  logic [31:0] w_aw_xaddr;
  logic        w_aw_in_range;

  axil_addr_xlate #(
    .OFFSET      (OFFSET),
    .LEFT_SHIFT  (LEFT_SHIFT),
    .WINDOW_SIZE (WINDOW_SIZE)
  ) u_xlate_ar (
    .i_addr     (s_araddr),
    .o_addr     (w_ar_xaddr),
    .o_in_range (w_ar_in_range)
  );

  axil_addr_xlate #(
    .OFFSET      (OFFSET),
    .LEFT_SHIFT  (LEFT_SHIFT),
    .WINDOW_SIZE (WINDOW_SIZE)
  ) u_xlate_aw (
    .i_addr     (s_awaddr),
    .o_addr     (w_aw_xaddr),
    .o_in_range (w_aw_in_range)
  );

`ifndef ADDR_WINDOW_CHECK_EN
  // Window result is not consulted when every request is forwarded.
  logic w_unused;
  assign w_unused = w_ar_in_range ^ w_aw_in_range;
`endif

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  rd_state_t   r_rd_state;
  rd_state_t   w_rd_next;
  logic [31:0] r_araddr;
  logic [2:0]  r_arprot;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        w_ar_hs;

  assign w_ar_hs = s_arvalid && s_arready;

  always_ff @(posedge clk) begin
    if (!rstn) r_rd_state <= R_IDLE;
    else       r_rd_state <= w_rd_next;
  end

  always_comb begin
    w_rd_next = r_rd_state;
    s_arready = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    s_rvalid  = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        s_arready = r_live;
        if (s_arvalid && r_live) begin
`ifdef ADDR_WINDOW_CHECK_EN
          w_rd_next = w_ar_in_range ? R_AR : R_ERR;
`else
          w_rd_next = R_AR;
`endif
        end
      end
      R_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) w_rd_next = R_WAIT;
      end
      R_WAIT: begin
        m_rready = 1'b1;
        if (m_rvalid) w_rd_next = R_RESP;
      end
      R_RESP: begin
        s_rvalid = 1'b1;
        if (s_rready) w_rd_next = R_IDLE;
      end
`ifdef ADDR_WINDOW_CHECK_EN
      R_ERR: begin
        s_rvalid = 1'b1;
        if (s_rready) w_rd_next = R_IDLE;
      end
`endif
      default: w_rd_next = R_IDLE;
    endcase
  end

  // On acceptance the response registers are preset: zero data, and the
  // DECERR code if the request will not be forwarded. A forwarded read then
  // overwrites them with the peripheral's answer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_araddr <= 32'h0;
      r_arprot <= 3'h0;
      r_rdata  <= 32'h0;
      r_rresp  <= RESP_OKAY;
    end else begin
      if (r_rd_state == R_IDLE && w_ar_hs) begin
        r_araddr <= w_ar_xaddr;
        r_arprot <= s_arprot;
        r_rdata  <= 32'h0;
`ifdef ADDR_WINDOW_CHECK_EN
        r_rresp  <= w_ar_in_range ? RESP_OKAY : RESP_DECERR;
`else
        r_rresp  <= RESP_OKAY;
`endif
      end
      if (r_rd_state == R_WAIT && m_rvalid) begin
        r_rdata <= m_rdata;
        r_rresp <= m_rresp;
      end
    end
  end

  assign m_araddr = r_araddr;
  assign m_arprot = r_arprot;
  assign s_rdata  = r_rdata;
  assign s_rresp  = r_rresp;

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------
  wr_state_t   r_wr_state;
  wr_state_t   w_wr_next;
  logic [31:0] r_awaddr;
  logic [2:0]  r_awprot;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_bresp;
  logic        r_aw_held;
  logic        r_w_held;
  logic        r_maw_done;
  logic        r_mw_done;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_aw_have;
  logic        w_w_have;
  logic        w_maw_fin;
  logic        w_mw_fin;

  assign w_aw_hs   = s_awvalid && s_awready;
  assign w_w_hs    = s_wvalid && s_wready;
  // "have" includes a handshake happening this cycle so the later of AW/W
  // moves the FSM on the same edge it is captured.
  assign w_aw_have = r_aw_held || w_aw_hs;
  assign w_w_have  = r_w_held || w_w_hs;
  assign w_maw_fin = r_maw_done || (m_awvalid && m_awready);
  assign w_mw_fin  = r_mw_done || (m_wvalid && m_wready);

`ifdef ADDR_WINDOW_CHECK_EN
  logic r_aw_ok;
  logic w_aw_ok;
  assign w_aw_ok = w_aw_hs ? w_aw_in_range : r_aw_ok;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) r_wr_state <= W_IDLE;
    else       r_wr_state <= w_wr_next;
  end

  always_comb begin
    w_wr_next = r_wr_state;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    s_bvalid  = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        s_awready = r_live && !r_aw_held;
        s_wready  = r_live && !r_w_held;
        if (w_aw_have && w_w_have) begin
`ifdef ADDR_WINDOW_CHECK_EN
          w_wr_next = w_aw_ok ? W_FWD : W_ERR;
`else
          w_wr_next = W_FWD;
`endif
        end
      end
      W_FWD: begin
        m_awvalid = !r_maw_done;
        m_wvalid  = !r_mw_done;
        if (w_maw_fin && w_mw_fin) w_wr_next = W_WAIT;
      end
      W_WAIT: begin
        m_bready = 1'b1;
        if (m_bvalid) w_wr_next = W_RESP;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) w_wr_next = W_IDLE;
      end
`ifdef ADDR_WINDOW_CHECK_EN
      W_ERR: begin
        s_bvalid = 1'b1;
        if (s_bready) w_wr_next = W_IDLE;
      end
`endif
      default: w_wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_awaddr   <= 32'h0;
      r_awprot   <= 3'h0;
      r_wdata    <= 32'h0;
      r_wstrb    <= 4'h0;
      r_bresp    <= RESP_OKAY;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_maw_done <= 1'b0;
      r_mw_done  <= 1'b0;
`ifdef ADDR_WINDOW_CHECK_EN
      r_aw_ok    <= 1'b0;
`endif
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awaddr  <= w_aw_xaddr;
            r_awprot  <= s_awprot;
            r_aw_held <= 1'b1;
`ifdef ADDR_WINDOW_CHECK_EN
            r_aw_ok   <= w_aw_in_range;
`endif
          end
          if (w_w_hs) begin
            r_wdata  <= s_wdata;
            r_wstrb  <= s_wstrb;
            r_w_held <= 1'b1;
          end
          // Leaving IDLE: release the hold flags (overrides the sets above).
          if (w_aw_have && w_w_have) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
`ifdef ADDR_WINDOW_CHECK_EN
            r_bresp   <= w_aw_ok ? RESP_OKAY : RESP_DECERR;
`else
            r_bresp   <= RESP_OKAY;
`endif
          end
        end
        W_FWD: begin
          if (m_awvalid && m_awready) r_maw_done <= 1'b1;
          if (m_wvalid && m_wready)   r_mw_done  <= 1'b1;
          if (w_maw_fin && w_mw_fin) begin
            r_maw_done <= 1'b0;
            r_mw_done  <= 1'b0;
          end
        end
        W_WAIT: begin
          if (m_bvalid) r_bresp <= m_bresp;
        end
        default: ;
      endcase
    end
  end

  assign m_awaddr = r_awaddr;
  assign m_awprot = r_awprot;
  assign m_wdata  = r_wdata;
  assign m_wstrb  = r_wstrb;
  assign s_bresp  = r_bresp;

endmodule : axil_window_bridge
`default_nettype wire

// File: tb/tb_axil_window_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axil_window_bridge
// Description : Scoreboard bench for axil_window_bridge. Directed stimulus
//               pushes expected master-side requests and slave-side responses
//               into queues; monitors pop and compare on each handshake.
//               Expectations follow ADDR_WINDOW_CHECK_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_window_bridge;
  import axil_pkg::*;

  localparam logic [31:0] P_OFFSET = 32'h1000_0000;
  localparam int unsigned P_SHIFT  = 2;
  localparam logic [31:0] P_WINDOW = 32'h100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [31:0] s_araddr;  logic [2:0] s_arprot;  logic s_arvalid, s_arready;
  logic [31:0] s_rdata;   logic [1:0] s_rresp;   logic s_rvalid,  s_rready;
  logic [31:0] s_awaddr;  logic [2:0] s_awprot;  logic s_awvalid, s_awready;
  logic [31:0] s_wdata;   logic [3:0] s_wstrb;   logic s_wvalid,  s_wready;
  logic [1:0]  s_bresp;   logic s_bvalid, s_bready;
  logic [31:0] m_araddr;  logic [2:0] m_arprot;  logic m_arvalid, m_arready;
  logic [31:0] m_rdata;   logic [1:0] m_rresp;   logic m_rvalid,  m_rready;
  logic [31:0] m_awaddr;  logic [2:0] m_awprot;  logic m_awvalid, m_awready;
  logic [31:0] m_wdata;   logic [3:0] m_wstrb;   logic m_wvalid,  m_wready;
  logic [1:0]  m_bresp;   logic m_bvalid, m_bready;

  axil_window_bridge #(
    .OFFSET(P_OFFSET), .LEFT_SHIFT(P_SHIFT), .WINDOW_SIZE(P_WINDOW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  int checks = 0;
  int errors = 0;

  logic [34:0] q_ar[$];   // {prot, addr} expected on the master AR channel
  logic [34:0] q_aw[$];   // {prot, addr} expected on the master AW channel
  logic [35:0] q_w[$];    // {data, strb} expected on the master W channel
  logic [33:0] q_r[$];    // {data, resp} expected on the slave R channel
  logic [1:0]  q_b[$];    // resp expected on the slave B channel

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // ---------------------------------------------------------------- monitors
  always @(negedge clk) begin
    if (rstn && m_arvalid && m_arready) begin
      if (q_ar.size() == 0) unexpected("m_ar", {29'h0, m_arprot, m_araddr});
      else chk("m_ar", {29'h0, m_arprot, m_araddr}, {29'h0, q_ar.pop_front()});
    end
    if (rstn && m_awvalid && m_awready) begin
      if (q_aw.size() == 0) unexpected("m_aw", {29'h0, m_awprot, m_awaddr});
      else chk("m_aw", {29'h0, m_awprot, m_awaddr}, {29'h0, q_aw.pop_front()});
    end
    if (rstn && m_wvalid && m_wready) begin
      if (q_w.size() == 0) unexpected("m_w", {28'h0, m_wdata, m_wstrb});
      else chk("m_w", {28'h0, m_wdata, m_wstrb}, {28'h0, q_w.pop_front()});
    end
    if (rstn && s_rvalid && s_rready) begin
      if (q_r.size() == 0) unexpected("s_r", {30'h0, s_rdata, s_rresp});
      else chk("s_r", {30'h0, s_rdata, s_rresp}, {30'h0, q_r.pop_front()});
    end
    if (rstn && s_bvalid && s_bready) begin
      if (q_b.size() == 0) unexpected("s_b", {62'h0, s_bresp});
      else chk("s_b", {62'h0, s_bresp}, {62'h0, q_b.pop_front()});
    end
  end

  // ------------------------------------------------------------------ tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [2:0] p);
    int n = 0;
    s_araddr = a; s_arprot = p; s_arvalid = 1'b1;
    @(negedge clk);
    while (!s_arready && n < 50) begin @(negedge clk); n++; end
    if (!s_arready) unexpected("ar_timeout", 64'(s_arready));
    tick();
    s_arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [2:0] p);
    int n = 0;
    s_awaddr = a; s_awprot = p; s_awvalid = 1'b1;
    @(negedge clk);
    while (!s_awready && n < 50) begin @(negedge clk); n++; end
    if (!s_awready) unexpected("aw_timeout", 64'(s_awready));
    tick();
    s_awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    @(negedge clk);
    while (!s_wready && n < 50) begin @(negedge clk); n++; end
    if (!s_wready) unexpected("w_timeout", 64'(s_wready));
    tick();
    s_wvalid = 1'b0;
  endtask

  task automatic wr_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    s_awaddr = a; s_awprot = 3'b000; s_awvalid = 1'b1;
    s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    @(negedge clk);
    chk("both_awready", 64'(s_awready), 64'd1);
    chk("both_wready", 64'(s_wready), 64'd1);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  // Peripheral side of a read; called right after the AR handshake.
  task automatic serve_read(input logic [31:0] d, input logic [1:0] r);
    m_arready = 1'b1;
    @(negedge clk);
    chk("m_arvalid_lat", 64'(m_arvalid), 64'd1);
    tick();
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = d; m_rresp = r;
    @(negedge clk);
    chk("m_arvalid_drop", 64'(m_arvalid), 64'd0);
    chk("m_rready", 64'(m_rready), 64'd1);
    chk("s_rvalid_early", 64'(s_rvalid), 64'd0);
    tick();
    m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
    @(negedge clk);
    chk("s_rvalid_lat", 64'(s_rvalid), 64'd1);
  endtask

  // Peripheral side of a write; W accepted one cycle before AW.
  task automatic serve_write(input bit do_b, input logic [1:0] r);
    m_wready = 1'b1;
    @(negedge clk);
    chk("m_awvalid_lat", 64'(m_awvalid), 64'd1);
    chk("m_wvalid_lat", 64'(m_wvalid), 64'd1);
    tick();
    m_wready = 1'b0; m_awready = 1'b1;
    @(negedge clk);
    chk("m_wvalid_drop", 64'(m_wvalid), 64'd0);
    chk("m_awvalid_hold", 64'(m_awvalid), 64'd1);
    tick();
    m_awready = 1'b0;
    if (do_b) begin m_bvalid = 1'b1; m_bresp = r; end
    @(negedge clk);
    chk("m_awvalid_drop", 64'(m_awvalid), 64'd0);
    chk("m_bready", 64'(m_bready), 64'd1);
    chk("s_bvalid_early", 64'(s_bvalid), 64'd0);
    if (do_b) begin
      tick();
      m_bvalid = 1'b0; m_bresp = 2'b00;
      @(negedge clk);
      chk("s_bvalid_lat", 64'(s_bvalid), 64'd1);
    end
  endtask

  // ------------------------------------------------------------------ main
  initial begin
    rstn = 1'b0;
    s_araddr = '0; s_arprot = '0; s_arvalid = 1'b0; s_rready = 1'b1;
    s_awaddr = '0; s_awprot = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b1;
    m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rvalid = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = '0; m_bvalid = 1'b0;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_readies", {61'h0, s_arready, s_awready, s_wready}, 64'h0);
    chk("rst_valids", {59'h0, s_rvalid, s_bvalid, m_arvalid, m_awvalid, m_wvalid}, 64'h0);
    chk("rst_mready", {62'h0, m_rready, m_bready}, 64'h0);
    chk("rst_resp", {30'h0, s_rdata, s_rresp}, 64'h0);
    chk("rst_bresp", 64'(s_bresp), 64'h0);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_arready_low", 64'(s_arready), 64'd0);
    tick();
    @(negedge clk);
    chk("rel_arready_high", 64'(s_arready), 64'd1);
    tick();

    // 1: in-window read
    q_ar.push_back({3'b010, 32'h0000_0010});
    q_r.push_back({32'hDEAD_BEEF, RESP_OKAY});
    ar_send(32'h1000_0004, 3'b010);
    serve_read(32'hDEAD_BEEF, RESP_OKAY);
    tick();

    // 2 / 6: first address past the window
`ifdef ADDR_WINDOW_CHECK_EN
    q_r.push_back({32'h0, RESP_DECERR});
    ar_send(32'h1000_0100, 3'b000);
    @(negedge clk);
    chk("err_rvalid_lat", 64'(s_rvalid), 64'd1);
    chk("err_no_arvalid", 64'(m_arvalid), 64'd0);
    tick();
    @(negedge clk);
    chk("err_no_arvalid2", 64'(m_arvalid), 64'd0);
    chk("err_rvalid_drop", 64'(s_rvalid), 64'd0);
    chk("err_arready_back", 64'(s_arready), 64'd1);
    tick();
`else
    q_ar.push_back({3'b000, 32'h0000_0400});
    q_r.push_back({32'h0BAD_0400, RESP_OKAY});
    ar_send(32'h1000_0100, 3'b000);
    serve_read(32'h0BAD_0400, RESP_OKAY);
    tick();
`endif

    // last in-window word
    q_ar.push_back({3'b001, 32'h0000_03F0});
    q_r.push_back({32'hA5A5_0FC0, RESP_OKAY});
    ar_send(32'h1000_00FC, 3'b001);
    serve_read(32'hA5A5_0FC0, RESP_OKAY);
    tick();

    // 4: slave R backpressure, SLVERR passed through
    s_rready = 1'b0;
    q_ar.push_back({3'b000, 32'h0000_0040});
    q_r.push_back({32'hCAFE_F00D, 2'b10});
    ar_send(32'h1000_0010, 3'b000);
    serve_read(32'hCAFE_F00D, 2'b10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rvalid", 64'(s_rvalid), 64'd1);
      chk("bp_rdata", {30'h0, s_rdata, s_rresp}, {30'h0, 32'hCAFE_F00D, 2'b10});
      chk("bp_arready", 64'(s_arready), 64'd0);
    end
    tick();
    s_rready = 1'b1;
    tick();

    // 3: W three cycles ahead of AW
    q_w.push_back({32'h0000_1234, 4'hF});
    q_aw.push_back({3'b011, 32'h0000_0020});
    q_b.push_back(RESP_OKAY);
    w_send(32'h0000_1234, 4'hF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wfirst_wready", 64'(s_wready), 64'd0);
      chk("wfirst_awready", 64'(s_awready), 64'd1);
      chk("wfirst_no_fwd", {62'h0, m_awvalid, m_wvalid}, 64'h0);
      tick();
    end
    aw_send(32'h1000_0008, 3'b011);
    serve_write(1'b1, RESP_OKAY);
    tick();

    // out-of-window write, AW and W together
`ifdef ADDR_WINDOW_CHECK_EN
    q_b.push_back(RESP_DECERR);
    wr_both(32'h1000_0200, 32'h7777_7777, 4'h1);
    @(negedge clk);
    chk("werr_bvalid_lat", 64'(s_bvalid), 64'd1);
    chk("werr_no_fwd", {62'h0, m_awvalid, m_wvalid}, 64'h0);
    tick();
    @(negedge clk);
    chk("werr_bvalid_drop", 64'(s_bvalid), 64'd0);
    chk("werr_awready_back", 64'(s_awready), 64'd1);
    tick();
`else
    q_aw.push_back({3'b000, 32'h0000_0800});
    q_w.push_back({32'h7777_7777, 4'h1});
    q_b.push_back(2'b10);
    wr_both(32'h1000_0200, 32'h7777_7777, 4'h1);
    serve_write(1'b1, 2'b10);
    tick();
`endif

    // 5: reset while waiting for B
    q_aw.push_back({3'b000, 32'h0000_0030});
    q_w.push_back({32'h0000_55AA, 4'h3});
    wr_both(32'h1000_000C, 32'h0000_55AA, 4'h3);
    serve_write(1'b0, RESP_OKAY);
    tick();
    rstn = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_rst_valids", {59'h0, s_rvalid, s_bvalid, m_arvalid, m_awvalid, m_wvalid}, 64'h0);
    chk("mid_rst_mready", {62'h0, m_rready, m_bready}, 64'h0);
    chk("mid_rst_readies", {61'h0, s_arready, s_awready, s_wready}, 64'h0);
    tick();
    rstn = 1'b1;
    m_bvalid = 1'b1; m_bresp = RESP_OKAY;
    @(negedge clk);
    chk("late_b_arready_low", 64'(s_arready), 64'd0);
    tick();
    @(negedge clk);
    chk("late_b_readies", {61'h0, s_arready, s_awready, s_wready}, 64'h7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_b_ignored", {62'h0, s_bvalid, m_bready}, 64'h0);
    end
    tick();
    m_bvalid = 1'b0;
    repeat (3) tick();

    chk("q_ar_empty", 64'(q_ar.size()), 64'd0);
    chk("q_aw_empty", 64'(q_aw.size()), 64'd0);
    chk("q_w_empty", 64'(q_w.size()), 64'd0);
    chk("q_r_empty", 64'(q_r.size()), 64'd0);
    chk("q_b_empty", 64'(q_b.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_axil_window_bridge
`default_nettype wire
